// File: rtl/watch_time_setter.sv
// Time-setting controller: captures the live BCD time, lets the user edit hour/minute/second
// with BCD wrap, and commits only the edited fields as one-cycle load pulses.
module watch_time_setter #(
   parameter int unsigned BLINK_MS   = 500,
   parameter int unsigned TIMEOUT_MS = 30000
) (
   input  logic       clk,
   input  logic       reset_p,
   input  logic       clk_msec,
   input  logic       btn_set,
   input  logic       btn_sel,
   input  logic       btn_inc,
   input  logic       btn_dec,
   input  logic [3:0] cur_hour10,
   input  logic [3:0] cur_hour1,
   input  logic [3:0] cur_min10,
   input  logic [3:0] cur_min1,
   input  logic [3:0] cur_sec10,
   input  logic [3:0] cur_sec1,
   output logic [3:0] set_hour10,
   output logic [3:0] set_hour1,
   output logic [3:0] set_min10,
   output logic [3:0] set_min1,
   output logic [3:0] set_sec10,
   output logic [3:0] set_sec1,
   output logic       load_hour,
   output logic       load_min,
   output logic       load_sec,
   output logic       set_mode,
   output logic [1:0] field_sel,
   output logic       blink
);

   localparam int BW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
   localparam int TW = (TIMEOUT_MS > 1) ? $clog2(TIMEOUT_MS) : 1;
   localparam bit TIMEOUT_EN = (TIMEOUT_MS != 0);

   localparam logic [1:0] F_HOUR = 2'd0;
   localparam logic [1:0] F_MIN  = 2'd1;
   localparam logic [1:0] F_SEC  = 2'd2;
   localparam logic [1:0] F_NONE = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CAPTURE,
      S_EDIT,
      S_COMMIT
   } state_t;

   state_t        state;
   logic [2:0]    dirty;        // {hour, min, sec}
   logic [BW-1:0] blink_cnt;
   logic [TW-1:0] timeout_cnt;

   logic [3:0] sel_tens, sel_ones, max_tens, max_ones;
   logic [7:0] stepped;

   // One BCD step of a tens:ones pair bounded by max_tens:max_ones; anything out of range lands on 00.
   function automatic logic [7:0] bcd_step(input logic [3:0] tens, input logic [3:0] ones,
                                           input logic [3:0] top_tens, input logic [3:0] top_ones,
                                           input logic up);
      logic in_range;
      in_range = (ones <= 4'd9) &&
                 ((tens < top_tens) || ((tens == top_tens) && (ones <= top_ones)));
      if (!in_range) return 8'h00;
      if (up) begin
         if ((tens == top_tens) && (ones == top_ones)) return 8'h00;
         if (ones == 4'd9) return {tens + 4'd1, 4'd0};
         return {tens, ones + 4'd1};
      end
      if ((tens == 4'd0) && (ones == 4'd0)) return {top_tens, top_ones};
      if (ones == 4'd0) return {tens - 4'd1, 4'd9};
      return {tens, ones - 4'd1};
   endfunction

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      sel_tens = set_hour10;
      sel_ones = set_hour1;
      max_tens = 4'd2;
      max_ones = 4'd3;
      case (field_sel)
         F_MIN: begin
            sel_tens = set_min10;
            sel_ones = set_min1;
            max_tens = 4'd5;
            max_ones = 4'd9;
         end
         F_SEC: begin
            sel_tens = set_sec10;
            sel_ones = set_sec1;
            max_tens = 4'd5;
            max_ones = 4'd9;
         end
         default: ;
      endcase
      stepped = bcd_step(sel_tens, sel_ones, max_tens, max_ones, btn_inc);
   end

   // NOTE: state and registered outputs use non-blocking assignments so every read sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset_p) begin
         state       <= S_IDLE;
         set_hour10  <= 4'd0;
         set_hour1   <= 4'd0;
         set_min10   <= 4'd0;
         set_min1    <= 4'd0;
         set_sec10   <= 4'd0;
         set_sec1    <= 4'd0;
         load_hour   <= 1'b0;
         load_min    <= 1'b0;
         load_sec    <= 1'b0;
         set_mode    <= 1'b0;
         field_sel   <= F_NONE;
         blink       <= 1'b0;
         dirty       <= 3'b000;
         blink_cnt   <= '0;
         timeout_cnt <= '0;
      end else begin
         load_hour <= 1'b0;
         load_min  <= 1'b0;
         load_sec  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (btn_set) begin
                  state    <= S_CAPTURE;
                  set_mode <= 1'b1;
               end
            end

            S_CAPTURE: begin
               set_hour10  <= cur_hour10;
               set_hour1   <= cur_hour1;
               set_min10   <= cur_min10;
               set_min1    <= cur_min1;
               set_sec10   <= cur_sec10;
               set_sec1    <= cur_sec1;
               dirty       <= 3'b000;
               field_sel   <= F_HOUR;
               blink       <= 1'b1;
               blink_cnt   <= '0;
               timeout_cnt <= '0;
               state       <= S_EDIT;
            end

            S_EDIT: begin
               if (btn_set) begin
                  {load_hour, load_min, load_sec} <= dirty;
                  blink <= 1'b0;
                  state <= S_COMMIT;
               end else if (btn_sel) begin
                  field_sel   <= (field_sel == F_SEC) ? F_HOUR : field_sel + 2'd1;
                  blink       <= 1'b1;
                  blink_cnt   <= '0;
                  timeout_cnt <= '0;
               end else if (btn_inc || btn_dec) begin
                  blink       <= 1'b1;
                  blink_cnt   <= '0;
                  timeout_cnt <= '0;
                  // Opposing presses cancel: no value change and the field stays clean.
                  if (btn_inc != btn_dec) begin
                     case (field_sel)
                        F_HOUR: begin
                           {set_hour10, set_hour1} <= stepped;
                           dirty[2] <= 1'b1;
                        end
                        F_MIN: begin
                           {set_min10, set_min1} <= stepped;
                           dirty[1] <= 1'b1;
                        end
                        F_SEC: begin
                           {set_sec10, set_sec1} <= stepped;
                           dirty[0] <= 1'b1;
                        end
                        default: ;
                     endcase
                  end
               end else if (clk_msec) begin
                  timeout_cnt <= timeout_cnt + TW'(1);
                  if (TIMEOUT_EN && (timeout_cnt == TW'(TIMEOUT_MS - 1))) begin
                     state     <= S_IDLE;
                     set_mode  <= 1'b0;
                     field_sel <= F_NONE;
                     blink     <= 1'b0;
                  end else if (blink_cnt == BW'(BLINK_MS - 1)) begin
                     blink     <= ~blink;
                     blink_cnt <= '0;
                  end else begin
                     blink_cnt <= blink_cnt + BW'(1);
                  end
               end
            end

            S_COMMIT: begin
               state     <= S_IDLE;
               set_mode  <= 1'b0;
               field_sel <= F_NONE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
